// File: rtl/vector_divider_32bit.sv
`timescale 1ns/1ps
`default_nettype none
// +-----------------------------------------------------------------------+
// | vector_divider_32bit: iterative unsigned SIMD restoring divider,      |
// | 4x8 / 2x16 / 1x32 lanes, one quotient bit per lane per cycle.         |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
module vector_divider_32bit (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] dividend_32bit,
   input  logic [31:0] divisor_32bit,
   input  logic [1:0]  precision,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] quotient_32bit,
   output logic [31:0] remainder_32bit,
   output logic [3:0]  div_by_zero
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t      r_state;
   state_t      w_state_nxt;

   logic [31:0] r_dvd;
   logic [31:0] r_dvs;
   logic [31:0] r_rem;
   logic [1:0]  r_prec;
   logic [5:0]  r_count;

   logic [31:0] w_rem_nxt;
   logic [31:0] w_dvd_nxt;
   logic [32:0] w_res;
   logic [3:0]  w_dbz;
   logic [5:0]  w_last_idx;
   logic        w_accept;
   logic        w_last;

   // Lane-agnostic step: operands arrive zero-extended, so one 33-bit
   // compare/subtract serves every lane width without borrow leakage.
   function automatic logic [32:0] div_step(input logic [32:0] rem_sh,
                                            input logic [31:0] dvs);
      logic [31:0] diff;
      diff = rem_sh[31:0] - dvs;
      if (rem_sh >= {1'b0, dvs})
         div_step = {1'b1, diff};
      else
         div_step = {1'b0, rem_sh[31:0]};
   endfunction

   always_comb begin
      w_rem_nxt = r_rem;
      w_dvd_nxt = r_dvd;
      w_res     = '0;
      case (r_prec)
         2'b00: begin
            for (int i = 0; i < 4; i++) begin
               w_res = div_step({24'd0, r_rem[i*8 +: 8], r_dvd[i*8+7]},
                                {24'd0, r_dvs[i*8 +: 8]});
               w_rem_nxt[i*8 +: 8] = w_res[7:0];
               w_dvd_nxt[i*8 +: 8] = {r_dvd[i*8 +: 7], w_res[32]};
            end
         end
         2'b01: begin
            for (int i = 0; i < 2; i++) begin
               w_res = div_step({16'd0, r_rem[i*16 +: 16], r_dvd[i*16+15]},
                                {16'd0, r_dvs[i*16 +: 16]});
               w_rem_nxt[i*16 +: 16] = w_res[15:0];
               w_dvd_nxt[i*16 +: 16] = {r_dvd[i*16 +: 15], w_res[32]};
            end
         end
         default: begin
            w_res     = div_step({r_rem, r_dvd[31]}, r_dvs);
            w_rem_nxt = w_res[31:0];
            w_dvd_nxt = {r_dvd[30:0], w_res[32]};
         end
      endcase
   end

   always_comb begin
      w_dbz      = '0;
      w_last_idx = 6'd31;
      case (r_prec)
         2'b00: begin
            w_last_idx = 6'd7;
            for (int i = 0; i < 4; i++)
               w_dbz[i] = (r_dvs[i*8 +: 8] == 8'd0);
         end
         2'b01: begin
            w_last_idx = 6'd15;
            w_dbz      = {{2{r_dvs[31:16] == 16'd0}}, {2{r_dvs[15:0] == 16'd0}}};
         end
         default: begin
            w_last_idx = 6'd31;
            w_dbz      = {4{r_dvs == 32'd0}};
         end
      endcase
   end

   assign w_last   = (r_count == w_last_idx);
   assign w_accept = in_valid && (r_state == IDLE);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         r_state <= IDLE;
      else
         r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      in_ready    = 1'b0;
      out_valid   = 1'b0;
      case (r_state)
         IDLE: begin
            in_ready = rst;
            if (in_valid)
               w_state_nxt = BUSY;
         end
         BUSY: begin
            if (w_last)
               w_state_nxt = DONE;
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready)
               w_state_nxt = IDLE;
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   // Quotient bits replace dividend bits as they shift out of r_dvd.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_dvd           <= '0;
         r_dvs           <= '0;
         r_rem           <= '0;
         r_prec          <= '0;
         r_count         <= '0;
         quotient_32bit  <= '0;
         remainder_32bit <= '0;
         div_by_zero     <= '0;
      end else if (w_accept) begin
         r_dvd   <= dividend_32bit;
         r_dvs   <= divisor_32bit;
         r_prec  <= precision;
         r_rem   <= '0;
         r_count <= '0;
      end else if (r_state == BUSY) begin
         r_dvd   <= w_dvd_nxt;
         r_rem   <= w_rem_nxt;
         r_count <= r_count + 6'd1;
         if (w_last) begin
            quotient_32bit  <= w_dvd_nxt;
            remainder_32bit <= w_rem_nxt;
            div_by_zero     <= w_dbz;
         end
      end
   end

endmodule
`default_nettype wire
